// File: rtl/matmul_uc_sequencer.sv
// matmul_uc_sequencer: fetch-redirect control for the MATMUL2 microcode ROM.
// Rev 1.0 - initial release.
`default_nettype none

module matmul_uc_sequencer #(
  parameter int         XLEN        = 32,
  parameter logic [6:0] OP_START    = 7'b1111010,
  parameter logic [6:0] OP_END      = 7'b1111100,
  parameter int         WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic            StallF,
  input  logic            err_clr,
  output logic [1:0]      fsm_state,
  output logic [1:0]      im_sel,
  output logic            pc_mux_sel,
  output logic            save_pc,
  output logic            reset_pc,
  output logic [XLEN-1:0] pc_backup,
  output logic            start_matmul2,
  output logic            end_matmul,
  output logic            flush_d,
  output logic            busy,
  output logic [15:0]     uc_cycles,
  output logic            err_nested,
  output logic            err_orphan,
  output logic            err_timeout
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    MATMUL2 = 2'b01
  } state_t;

  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

  state_t     state;
  logic       in_mm;
  logic [6:0] opcode;
  logic       hit_s;
  logic       hit_e;
  logic       wdog_fire;

  // Encodings 10/11 fall through as NORMAL because only MATMUL2 is decoded.
  assign in_mm  = (state == MATMUL2);
  assign opcode = InstrF[6:0];
  assign hit_s  = !StallF && (opcode == OP_START);
  assign hit_e  = !StallF && (opcode == OP_END);

  assign start_matmul2 = !in_mm && hit_s;
  assign end_matmul    = in_mm && hit_e;
  // A real end in the expiry cycle takes precedence over the watchdog.
  assign wdog_fire     = in_mm && !end_matmul && ({16'd0, uc_cycles} == WDOG_LAST);

  assign save_pc    = start_matmul2;
  assign reset_pc   = start_matmul2;
  assign pc_mux_sel = !(end_matmul || wdog_fire);
  assign flush_d    = hit_s || hit_e || wdog_fire;
  assign fsm_state  = in_mm ? 2'b01 : 2'b00;
  assign im_sel     = in_mm ? 2'b01 : 2'b00;
  assign busy       = in_mm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NORMAL;
      pc_backup   <= '0;
      uc_cycles   <= '0;
      err_nested  <= 1'b0;
      err_orphan  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_nested  <= (err_nested  && !err_clr) || (in_mm && hit_s);
      err_orphan  <= (err_orphan  && !err_clr) || (!in_mm && hit_e);
      err_timeout <= (err_timeout && !err_clr) || wdog_fire;

      if (start_matmul2) begin
        state     <= MATMUL2;
        pc_backup <= PCF + XLEN'(4);
        uc_cycles <= '0;
      end else if (in_mm) begin
        if (uc_cycles != 16'hFFFF)
          uc_cycles <= uc_cycles + 16'd1;
        state <= (end_matmul || wdog_fire) ? NORMAL : MATMUL2;
      end else begin
        state <= NORMAL;
      end
    end
  end

endmodule

`default_nettype wire
